// File: rtl/ifm_rd_if.sv
// ifm_rd_if: request, AXI read (AR/R) and line-buffer write signals of the IFM read engine
interface ifm_rd_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int BUF_AW = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic              arvalid;
  logic              arready;
  logic [AW-1:0]     araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              buf_wready;
  logic              buf_we;
  logic [BUF_AW-1:0] buf_waddr;
  logic [DW-1:0]     buf_wdata;
  modport master (
    input  req_valid, req_addr, arready, rvalid, rdata, rresp, rlast, buf_wready,
    output req_ready, arvalid, araddr, arlen, arsize, arburst, rready, buf_we, buf_waddr, buf_wdata
  );
  modport slave (
    output req_valid, req_addr, arready, rvalid, rdata, rresp, rlast, buf_wready,
    input  req_ready, arvalid, araddr, arlen, arsize, arburst, rready, buf_we, buf_waddr, buf_wdata
  );
endinterface

// File: rtl/ifm_rd_engine.sv
// ifm_rd_engine: AXI4 INCR-burst read master streaming IFM beats into the line buffer
module ifm_rd_engine #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int BURST = 32,
  parameter int BUF_AW = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     map_start_i,
  ifm_rd_if.master bus,
  output logic     burst_done_o,
  output logic     busy_o,
  output logic     err_o
);
  localparam int CW = $clog2(BURST) + 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t            state_q, state_d;
  logic [AW-1:0]     araddr_q, araddr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BUF_AW-1:0] wptr_q, wptr_d, waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d, done_q, done_d, err_q, err_d;
  logic              beat, last_cnt, fin, bad;
  assign bus.req_ready  = state_q == IDLE;
  assign bus.arvalid    = state_q == ADDR;
  assign bus.araddr     = araddr_q;
  assign bus.arlen      = 8'(BURST - 1);
  assign bus.arsize     = 3'($clog2(DW / 8));
  assign bus.arburst    = 2'b01;
  assign bus.rready     = (state_q == DATA) & bus.buf_wready;
  assign bus.buf_we     = we_q;
  assign bus.buf_waddr  = waddr_q;
  assign bus.buf_wdata  = wdata_q;
  assign burst_done_o   = done_q;
  assign busy_o         = state_q != IDLE;
  assign err_o          = err_q;
  assign beat     = bus.rvalid & bus.rready;
  assign last_cnt = cnt_q == CW'(BURST - 1);
  assign fin      = beat & (last_cnt | bus.rlast);
  // early rlast and missing rlast on the final beat are both protocol errors
  assign bad      = beat & ((bus.rresp != 2'b00) | (bus.rlast ^ last_cnt));
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | bad;
    wptr_d   = beat ? wptr_q + 1'b1 : wptr_q;
    waddr_d  = beat ? wptr_q : waddr_q;
    wdata_d  = beat ? bus.rdata : wdata_q;
    we_d     = beat;
    done_d   = fin;
    case (state_q)
      IDLE: begin
        if (map_start_i) begin
          wptr_d = '0;
          err_d  = 1'b0;
        end
        if (bus.req_valid) begin
          araddr_d = bus.req_addr;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (bus.arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) cnt_d = cnt_q + 1'b1;
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule
